turn_latch: RTL and testbench
=============================

TURN_LATCH -- requirements
Module: turn_latch

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 50000, cycles a prefix state may wait for its next byte before abandoning the sequence.
REQ-002 CLOCK_50  input  1  system clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  synchronous, active-low reset.
REQ-004 game_tick  input  1  one-cycle pulse in the CLOCK_50 domain marking a game step.
REQ-005 code_valid  input  1  one-cycle strobe qualifying code.
REQ-006 code  input  8  raw PS/2 set-2 scancode byte.
REQ-007 turn  output  6  per-player turn request, 2 bits per player, player p at [2p+1:2p]; 01 right, 10 left, 00 none.
REQ-008 enter_req  output  1  Enter pressed during the previous tick window.
REQ-009 last_code  output  8  most recent non-prefix byte, for LED debug.

Function
REQ-010 Parser FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen).
REQ-011 IDLE: E0 -> EXT; F0 -> BRK; any other byte -> make event, non-extended, stay IDLE.
REQ-012 EXT: F0 -> EXT_BRK; E0 -> stay EXT; other byte -> make event, extended, -> IDLE.
REQ-013 BRK: any byte -> break event, non-extended, -> IDLE; EXT_BRK: any byte -> break event, extended, -> IDLE.
REQ-014 Key map: P0 left 1C, right 23; P1 left 3B, right 4B; P2 left E0 6B, right E0 74; Enter 5A non-extended; ext flag must match exactly, otherwise no action.
REQ-015 Make of a mapped turn key writes that player's pending request (10 left, 01 right); last make in a window wins; typematic repeats rewrite the same value.
REQ-016 Make of Enter sets enter_pending; break events never alter pending requests.
REQ-017 On game_tick: turn <= pending (all players), enter_req <= enter_pending, then pending and enter_pending cleared; outputs are held until the next game_tick.
REQ-018 Event and game_tick in the same cycle: the event lands in the new (post-clear) pending set, never lost, never in the current turn output.
REQ-019 Timeout counter reloads on every code_valid; if in EXT, BRK or EXT_BRK with no byte for TIMEOUT_CYCLES cycles, FSM returns to IDLE and the partial sequence is discarded.
REQ-020 last_code updated on every non-prefix byte (not E0/F0), independent of mapping.
REQ-021 Output latency: a make event is visible on turn exactly one cycle after the next game_tick.

Reset
REQ-022 While reset_n=0 at a clock edge: FSM IDLE, turn=0, enter_req=0, last_code=0, pending and held flags cleared, timeout counter reloaded.
REQ-023 Reset mid-sequence (e.g. after E0) discards the prefix; next byte parses from IDLE.

Configuration
REQ-024 Macro TURN_LATCH_HOLD_EN defined: per turn key held flag set on make, cleared on break; at game_tick a player with pending 00 and exactly one of its left/right keys held outputs that direction; pending still has priority.
REQ-025 TURN_LATCH_HOLD_EN undefined: no held flags; turns are strictly one-shot per make event.

Verification
REQ-026 Bytes 1C then game_tick -> turn=6'b000010, enter_req=0; following tick with no input -> turn=0.
REQ-027 Bytes E0 74, 3B, then 23 then 1C, then game_tick -> turn=6'b011010 (P0 left, P1 left, P2 right).
REQ-028 Bytes F0 1C then game_tick -> turn=0; byte 6B without E0 then tick -> turn=0, last_code=6B.
REQ-029 code_valid with 5A in the same cycle as game_tick -> enter_req=0 for that tick, enter_req=1 after the next tick.
REQ-030 Byte E0, idle TIMEOUT_CYCLES cycles, then 74, tick -> turn=0 (74 parsed non-extended, unmapped).
REQ-031 HOLD_EN: byte 23, ticks 1..3 with no break -> turn[1:0]=01 each tick; after F0 23, next tick -> 00; without HOLD_EN only tick 1 shows 01.

Source files
------------

// File: rtl/turn_latch.sv
// turn_latch: PS/2 set-2 scancode parser latching per-player turn requests and Enter per game tick.
// Optional feature: define TURN_LATCH_HOLD_EN so that held turn keys keep steering when nothing is pending.
module turn_latch #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic       game_tick,
    input  logic       code_valid,
    input  logic [7:0] code,
    output logic [5:0] turn,
    output logic       enter_req,
    output logic [7:0] last_code
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] RELOAD = CW'(TIMEOUT_CYCLES - 1);
    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;
    state_t state_q, state_d, byte_next;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [5:0] pend_q, pend_d, turn_q, turn_d, tick_turn;
    logic enter_pend_q, enter_pend_d, enter_req_q, enter_req_d;
    logic [7:0] last_code_q, last_code_d;
    logic is_e0, is_f0, is_ext, make_ev, brk_ev, enter_key;
    logic [2:0] key_l, key_r;
`ifdef TURN_LATCH_HOLD_EN
    logic [2:0] held_l_q, held_l_d, held_r_q, held_r_d;
`endif
    assign turn      = turn_q;
    assign enter_req = enter_req_q;
    assign last_code = last_code_q;
    assign is_e0     = code == 8'hE0;
    assign is_f0     = code == 8'hF0;
    assign is_ext    = state_q == EXT || state_q == EXT_BRK;
    assign make_ev   = code_valid && (state_q == IDLE || state_q == EXT) && !is_e0 && !is_f0;
    assign brk_ev    = code_valid && (state_q == BRK || state_q == EXT_BRK);
    assign key_l     = {is_ext && code == 8'h6B, !is_ext && code == 8'h3B, !is_ext && code == 8'h1C};
    assign key_r     = {is_ext && code == 8'h74, !is_ext && code == 8'h4B, !is_ext && code == 8'h23};
    assign enter_key = !is_ext && code == 8'h5A;
    // Next-state decode: parser transitions, prefix timeout, pending set and tick-time output latch.
    always_comb begin
        byte_next    = state_q == IDLE ? (is_e0 ? EXT : is_f0 ? BRK : IDLE)
                     : state_q == EXT  ? (is_f0 ? EXT_BRK : is_e0 ? EXT : IDLE)
                     : IDLE;
        state_d      = code_valid ? byte_next : (state_q != IDLE && cnt_q == '0) ? IDLE : state_q;
        cnt_d        = (code_valid || state_q == IDLE) ? RELOAD : cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
        last_code_d  = (code_valid && !is_e0 && !is_f0) ? code : last_code_q;
        pend_d       = game_tick ? 6'b0 : pend_q;
        enter_pend_d = (game_tick ? 1'b0 : enter_pend_q) | (make_ev && enter_key);
        tick_turn    = pend_q;
        for (int p = 0; p < 3; p++) begin
            if (make_ev && key_l[p]) pend_d[2*p +: 2] = 2'b10;
            else if (make_ev && key_r[p]) pend_d[2*p +: 2] = 2'b01;
`ifdef TURN_LATCH_HOLD_EN
            if (pend_q[2*p +: 2] == 2'b00 && (held_l_q[p] ^ held_r_q[p]))
                tick_turn[2*p +: 2] = {held_l_q[p], held_r_q[p]};
`endif
        end
        turn_d      = game_tick ? tick_turn : turn_q;
        enter_req_d = game_tick ? enter_pend_q : enter_req_q;
`ifdef TURN_LATCH_HOLD_EN
        held_l_d = make_ev ? held_l_q | key_l : brk_ev ? held_l_q & ~key_l : held_l_q;
        held_r_d = make_ev ? held_r_q | key_r : brk_ev ? held_r_q & ~key_r : held_r_q;
`endif
    end
    // State and output registers with synchronous active-low reset.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= RELOAD;
            pend_q       <= '0;
            enter_pend_q <= 1'b0;
            turn_q       <= '0;
            enter_req_q  <= 1'b0;
            last_code_q  <= '0;
`ifdef TURN_LATCH_HOLD_EN
            held_l_q     <= '0;
            held_r_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pend_q       <= pend_d;
            enter_pend_q <= enter_pend_d;
            turn_q       <= turn_d;
            enter_req_q  <= enter_req_d;
            last_code_q  <= last_code_d;
`ifdef TURN_LATCH_HOLD_EN
            held_l_q     <= held_l_d;
            held_r_q     <= held_r_d;
`endif
        end
    end
endmodule

// File: tb/tb_turn_latch.sv
// tb_turn_latch: directed scoreboard bench for turn_latch (expectations follow TURN_LATCH_HOLD_EN).
module tb_turn_latch;
    localparam int T = 20;
    localparam bit HOLD =
`ifdef TURN_LATCH_HOLD_EN
        1'b1;
`else
        1'b0;
`endif
    logic CLOCK_50 = 1'b0;
    logic reset_n = 1'b0, game_tick = 1'b0, code_valid = 1'b0;
    logic [7:0] code = 8'h00;
    logic [5:0] turn;
    logic enter_req;
    logic [7:0] last_code;
    int vectors = 0, errors = 0;
    typedef struct {
        string      tag;
        logic [5:0] t;
        logic       e;
    } exp_t;
    exp_t sb[$];

    turn_latch #(.TIMEOUT_CYCLES(T)) dut (
        .CLOCK_50(CLOCK_50), .reset_n(reset_n), .game_tick(game_tick), .code_valid(code_valid),
        .code(code), .turn(turn), .enter_req(enter_req), .last_code(last_code)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic tk, input logic v, input logic [7:0] b);
        game_tick = tk; code_valid = v; code = b;
        @(negedge CLOCK_50);
        game_tick = 1'b0; code_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        step(1'b0, 1'b1, b);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic tick_chk(input string tag, input logic v, input logic [7:0] b,
                            input logic [5:0] et, input logic ee);
        exp_t x;
        sb.push_back('{tag, et, ee});
        step(1'b1, v, b);
        x = sb.pop_front();
        chk({x.tag, "_turn"}, {2'b00, turn}, {2'b00, x.t});
        chk({x.tag, "_enter"}, {7'b0, enter_req}, {7'b0, x.e});
    endtask

    task automatic tick(input string tag, input logic [5:0] et, input logic ee);
        tick_chk(tag, 1'b0, 8'h00, et, ee);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge CLOCK_50);
        step(1'b0, 1'b1, 8'h1C);
        step(1'b1, 1'b0, 8'h00);
        chk("rst_turn", {2'b00, turn}, 8'h00);
        chk("rst_enter", {7'b0, enter_req}, 8'h00);
        chk("rst_last", last_code, 8'h00);
        reset_n = 1'b1;
        tick("rst_pending", 6'b0, 1'b0);
        // single make, then an empty window
        send(8'h1C);
        tick("p0_left", 6'b000010, 1'b0);
        tick("empty_window", HOLD ? 6'b000010 : 6'b0, 1'b0);
        send(8'hF0); send(8'h1C);
        tick("after_release", 6'b0, 1'b0);
        // three players in one window, last make wins for P0
        send(8'hE0); send(8'h74); send(8'h3B); send(8'h23); send(8'h1C);
        tick("three_players", 6'b011010, 1'b0);
        chk("last_1C", last_code, 8'h1C);
        send(8'hF0); send(8'h3B); send(8'hF0); send(8'h1C);
        send(8'hE0); send(8'hF0); send(8'h74); send(8'hF0); send(8'h23);
        chk("last_after_breaks", last_code, 8'h23);
        tick("all_released", 6'b0, 1'b0);
        // break only, and unextended 6B
        send(8'hF0); send(8'h1C);
        tick("break_only", 6'b0, 1'b0);
        send(8'h6B);
        tick("6B_no_ext", 6'b0, 1'b0);
        chk("last_6B", last_code, 8'h6B);
        // Enter coinciding with the tick lands in the next window
        tick_chk("enter_same_cycle", 1'b1, 8'h5A, 6'b0, 1'b0);
        tick("enter_next", 6'b0, 1'b1);
        tick("enter_cleared", 6'b0, 1'b0);
        send(8'hF0); send(8'h5A);
        tick("enter_break", 6'b0, 1'b0);
        // outputs held between ticks; last make wins; both held cancels
        send(8'h4B);
        chk("held_until_tick", {2'b00, turn}, 8'h00);
        send(8'h3B);
        tick("p1_last_wins", 6'b001000, 1'b0);
        tick("p1_both_held", 6'b0, 1'b0);
        send(8'hF0); send(8'h4B); send(8'hF0); send(8'h3B);
        tick("p1_released", 6'b0, 1'b0);
        // turn key coinciding with the tick
        tick_chk("turn_same_cycle", 1'b1, 8'h23, 6'b0, 1'b0);
        tick("turn_next", 6'b000001, 1'b0);
        send(8'hF0); send(8'h23);
        tick("turn_released", 6'b0, 1'b0);
        // prefix timeout boundaries
        send(8'hE0); idle(T); send(8'h74);
        tick("ext_timeout", 6'b0, 1'b0);
        chk("last_74", last_code, 8'h74);
        send(8'hE0); idle(T - 1); send(8'h74);
        tick("ext_just_in_time", 6'b010000, 1'b0);
        send(8'hE0); send(8'hF0); send(8'h74);
        tick("ext_released", 6'b0, 1'b0);
        send(8'hF0); idle(T); send(8'h1C);
        tick("brk_timeout_make", 6'b000010, 1'b0);
        send(8'hF0); send(8'h1C);
        tick("brk_released", 6'b0, 1'b0);
        // reset mid-sequence discards prefix and outputs
        send(8'h1C);
        tick("pre_reset", 6'b000010, 1'b0);
        send(8'hE0);
        reset_n = 1'b0;
        step(1'b0, 1'b0, 8'h00);
        reset_n = 1'b1;
        chk("reset_turn", {2'b00, turn}, 8'h00);
        chk("reset_last", last_code, 8'h00);
        send(8'h74);
        tick("reset_prefix_dropped", 6'b0, 1'b0);
        chk("reset_last_74", last_code, 8'h74);
        // typematic / held key over several ticks
        send(8'h23); send(8'h23);
        tick("hold_tick1", 6'b000001, 1'b0);
        tick("hold_tick2", HOLD ? 6'b000001 : 6'b0, 1'b0);
        tick("hold_tick3", HOLD ? 6'b000001 : 6'b0, 1'b0);
        send(8'hF0); send(8'h23);
        tick("hold_released", 6'b0, 1'b0);
        chk("scoreboard_drained", 8'(sb.size()), 8'h00);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
